// File: rtl/axis_src_rr_scheduler_if.sv
// rtl/axis_src_rr_scheduler_if.sv - source/sink handshake and select bus of the 16-source scheduler.
// master drives the FIFO flags and sink ready, slave is the scheduler producing the select code.
interface axis_src_rr_scheduler_if;
  logic [15:0] src_tvalid;
  logic [15:0] src_tlast;
  logic        sink_tready;
  logic [7:0]  bus_sel;
  logic        grant_valid;
  logic [3:0]  grant_idx;

  modport master (
    output src_tvalid, src_tlast, sink_tready,
    input  bus_sel, grant_valid, grant_idx
  );

  modport slave (
    input  src_tvalid, src_tlast, sink_tready,
    output bus_sel, grant_valid, grant_idx
  );
endinterface

// File: rtl/axis_src_rr_scheduler.sv
// rtl/axis_src_rr_scheduler.sv - packet-granular round-robin scheduler for a 16-source select path.
// Grants are held until the tlast beat or a watchdog release, then priority rotates past the winner.
module axis_src_rr_scheduler #(
  parameter int          NUM_SRC     = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int          CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sched_en,
  input  logic [15:0]                 src_mask,
  input  logic                        err_clr,
  axis_src_rr_scheduler_if.slave      sched,
  output logic                        pkt_done,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [3:0]       rr_ptr;
  logic [WD_W-1:0]  wd_cnt;
  logic [15:0]      req;
  logic             pick_found;
  logic [3:0]       pick_idx;
  logic             beat;

  assign req  = sched.src_tvalid & src_mask;
  assign beat = sched.src_tvalid[sched.grant_idx] & sched.sink_tready;

  // Circular search starting just after the last winner; the 4-bit cast gives the mod-16 wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 4'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!pick_found && req[4'(32'(rr_ptr) + k)]) begin
        pick_found = 1'b1;
        pick_idx   = 4'(32'(rr_ptr) + k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      sched.bus_sel     <= 8'd0;
      sched.grant_valid <= 1'b0;
      sched.grant_idx   <= 4'd0;
      pkt_done          <= 1'b0;
      timeout_err       <= 1'b0;
      pkt_count         <= '0;
      rr_ptr            <= 4'hF;
      wd_cnt            <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sched_en && pick_found) begin
            state             <= GRANT;
            sched.grant_idx   <= pick_idx;
            sched.grant_valid <= 1'b1;
            sched.bus_sel     <= {4'h8, pick_idx};
            rr_ptr            <= pick_idx;
            wd_cnt            <= '0;
          end
        end
        GRANT: begin
          if (beat) begin
            wd_cnt <= '0;
            if (sched.src_tlast[sched.grant_idx]) begin
              state             <= IDLE;
              sched.bus_sel     <= 8'd0;
              sched.grant_valid <= 1'b0;
              pkt_done          <= 1'b1;
              pkt_count         <= pkt_count + 1'b1;
            end
          end else if (TIMEOUT_CYC != 0 && wd_cnt == WD_W'(TIMEOUT_CYC)) begin
            // Placed after the err_clr clear so a simultaneous timeout wins.
            state             <= IDLE;
            sched.bus_sel     <= 8'd0;
            sched.grant_valid <= 1'b0;
            timeout_err       <= 1'b1;
          end else if (TIMEOUT_CYC != 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
